oven_key_conditioner: RTL and testbench

Input front end for the oven controller. It synchronises and debounces the two active-low push keys and classifies each press as an increment tap, a decrement tap or a two-key confirm chord. It also decodes the one-hot step switches into a step index. The setpoint-entry logic downstream consumes single-cycle `inc_pulse` / `dec_pulse` / `confirm_pulse` strobes instead of raw key levels.

---
 rtl/oven_key_conditioner.sv | 208 ++++++++++++++++++++
 tb/tb_oven_key_conditioner.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oven_key_conditioner.sv
// Oven key front end: synchronise/debounce two active-low keys, classify tap/chord/hold, decode step switches.
// Optional auto-repeat while a key is held is compiled in with `define OVEN_KEY_AUTOREPEAT_EN.
module oven_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CHORD_WINDOW    = 2500000
`ifdef OVEN_KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       key0,
    input  logic       key1,
    input  logic [5:0] sw,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       confirm_pulse,
    output logic [2:0] step_idx,
    output logic       keys_busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef OVEN_KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int WIN_MAX = (CHORD_WINDOW > RPT_MAX) ? CHORD_WINDOW : RPT_MAX;
`else
    localparam int WIN_MAX = CHORD_WINDOW;
`endif
    localparam int WIN_W = $clog2(WIN_MAX + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CHORD_WINDOW - 1);
`ifdef OVEN_KEY_AUTOREPEAT_EN
    localparam logic [WIN_W-1:0] RPT_FIRST = WIN_W'(REPEAT_DELAY - 1);
    localparam logic [WIN_W-1:0] RPT_NEXT  = WIN_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {IDLE, ONE, HELD, CHORD} state_t;

    // Index 0 is key0 (increment), index 1 is key1 (decrement).
    logic [1:0]      key_p0, key_p1;
    logic [5:0]      sw_p0, sw_p1;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      stable;
    logic [1:0]      press_evt;

    state_t          state;
    logic            first;
    logic [WIN_W-1:0] win_cnt;
`ifdef OVEN_KEY_AUTOREPEAT_EN
    logic [WIN_W-1:0] rep_cnt;
`endif

    logic other_press;
    logic first_rel;
    logic both_rel;

    function automatic logic [2:0] step_decode(input logic [5:0] s);
        logic [2:0] idx;
        idx = 3'd0;
        if (!s[5]) begin
            case (s[4:0])
                5'b00001: idx = 3'd1;
                5'b00010: idx = 3'd2;
                5'b00100: idx = 3'd3;
                5'b01000: idx = 3'd4;
                5'b10000: idx = 3'd5;
                default:  idx = 3'd0;
            endcase
        end
        return idx;
    endfunction

    // Stage p0/p1: two-flop synchronisers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_p0 <= 2'b11;
            key_p1 <= 2'b11;
            sw_p0  <= 6'd0;
            sw_p1  <= 6'd0;
        end else begin
            key_p0 <= {key1, key0};
            key_p1 <= key_p0;
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
        end
    end

    // Debounce: stable level flips after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
            stable    <= 2'b11;
            press_evt <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                press_evt[k] <= 1'b0;
                if (key_p1[k] == stable[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    db_cnt[k]    <= '0;
                    stable[k]    <= ~stable[k];
                    press_evt[k] <= stable[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_idx <= 3'd0;
        else        step_idx <= step_decode(sw_p1);
    end

    assign other_press = first ? press_evt[0] : press_evt[1];
    assign first_rel   = first ? stable[1] : stable[0];
    assign both_rel    = &stable;

    // Classifier: strobes are registered alongside the state they accompany
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            first         <= 1'b0;
            win_cnt       <= '0;
`ifdef OVEN_KEY_AUTOREPEAT_EN
            rep_cnt       <= '0;
`endif
            inc_pulse     <= 1'b0;
            dec_pulse     <= 1'b0;
            confirm_pulse <= 1'b0;
            keys_busy     <= 1'b0;
        end else begin
            inc_pulse     <= 1'b0;
            dec_pulse     <= 1'b0;
            confirm_pulse <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                keys_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (&press_evt) begin
                            state         <= CHORD;
                            confirm_pulse <= 1'b1;
                            keys_busy     <= 1'b1;
                        end else if (|press_evt) begin
                            state     <= ONE;
                            first     <= press_evt[1];
                            win_cnt   <= '0;
                            keys_busy <= 1'b1;
                        end
                    end
                    ONE: begin
                        // A second press beats a same-cycle release of the first key.
                        if (other_press) begin
                            state         <= CHORD;
                            confirm_pulse <= 1'b1;
                        end else if (first_rel) begin
                            state     <= IDLE;
                            keys_busy <= 1'b0;
                            inc_pulse <= ~first;
                            dec_pulse <= first;
                        end else if (win_cnt == WIN_LAST) begin
                            state     <= HELD;
                            inc_pulse <= ~first;
                            dec_pulse <= first;
`ifdef OVEN_KEY_AUTOREPEAT_EN
                            rep_cnt   <= RPT_FIRST;
`endif
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                        end
                    end
                    HELD: begin
                        if (both_rel) begin
                            state     <= IDLE;
                            keys_busy <= 1'b0;
                        end
`ifdef OVEN_KEY_AUTOREPEAT_EN
                        else if (rep_cnt == '0) begin
                            rep_cnt   <= RPT_NEXT;
                            inc_pulse <= ~first & ~first_rel;
                            dec_pulse <= first & ~first_rel;
                        end else begin
                            rep_cnt <= rep_cnt - WIN_W'(1);
                        end
`endif
                    end
                    CHORD: begin
                        if (both_rel) begin
                            state     <= IDLE;
                            keys_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        keys_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oven_key_conditioner.sv
// Directed plus randomized bench for oven_key_conditioner, checked cycle by cycle against a behavioural model.
module tb_oven_key_conditioner;
    localparam int DB = 4;
    localparam int CW = 16;
`ifdef OVEN_KEY_AUTOREPEAT_EN
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int HOLD = 50;
    localparam int HELD_DECS = 3;
`else
    localparam int HOLD = 30;
    localparam int HELD_DECS = 1;
`endif
    localparam int S_IDLE = 0, S_ONE = 1, S_HELD = 2, S_CHORD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       key0 = 1'b1;
    logic       key1 = 1'b1;
    logic [5:0] sw = 6'd0;
    logic       inc_pulse, dec_pulse, confirm_pulse, keys_busy;
    logic [2:0] step_idx;

    oven_key_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CHORD_WINDOW(CW)
`ifdef OVEN_KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .key0(key0),
        .key1(key1),
        .sw(sw),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .confirm_pulse(confirm_pulse),
        .step_idx(step_idx),
        .keys_busy(keys_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_inc = 0, obs_dec = 0, obs_conf = 0;
    int b_inc, b_dec, b_conf;

    // Reference model state
    int m_s0 [2];
    int m_s1 [2];
    int m_stab [2];
    int m_run [2];
    int m_pev [2];
    logic [5:0] m_sw0, m_sw1;
    int m_mode, m_first, m_t0, m_th;
    logic e_inc, e_dec, e_conf, e_busy;
    logic [2:0] e_step;

    function automatic int step_of(input logic [5:0] s);
        logic [4:0] low;
        low = s[4:0];
        if (s[5] || $countones(low) != 1) return 0;
        for (int k = 0; k < 5; k++) if (low[k]) return k + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s0[k] = 1; m_s1[k] = 1; m_stab[k] = 1; m_run[k] = 0; m_pev[k] = 0;
        end
        m_sw0 = 6'd0; m_sw1 = 6'd0;
        m_mode = S_IDLE; m_first = 0; m_t0 = 0; m_th = 0;
        e_inc = 1'b0; e_dec = 1'b0; e_conf = 1'b0; e_busy = 1'b0; e_step = 3'd0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        int pv [2];
        int st [2];
        int age;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            pv[k] = m_pev[k];
            st[k] = m_stab[k];
        end
        for (int k = 0; k < 2; k++) begin
            m_pev[k] = 0;
            if (m_s1[k] != m_stab[k]) begin
                m_run[k]++;
                if (m_run[k] == DB) begin
                    m_stab[k] = 1 - m_stab[k];
                    m_pev[k]  = (m_stab[k] == 0) ? 1 : 0;
                    m_run[k]  = 0;
                end
            end else begin
                m_run[k] = 0;
            end
            m_s1[k] = m_s0[k];
        end
        m_s0[0] = int'(key0);
        m_s0[1] = int'(key1);
        e_step = 3'(step_of(m_sw1));
        m_sw1 = m_sw0;
        m_sw0 = sw;
        e_inc = 1'b0; e_dec = 1'b0; e_conf = 1'b0;
        if (!en) begin
            m_mode = S_IDLE;
        end else begin
            case (m_mode)
                S_IDLE: begin
                    if (pv[0] == 1 && pv[1] == 1) begin
                        m_mode = S_CHORD; e_conf = 1'b1;
                    end else if (pv[0] == 1 || pv[1] == 1) begin
                        m_mode = S_ONE; m_first = pv[1]; m_t0 = cyc;
                    end
                end
                S_ONE: begin
                    age = cyc - m_t0;
                    if (pv[1 - m_first] == 1) begin
                        m_mode = S_CHORD; e_conf = 1'b1;
                    end else if (st[m_first] == 1) begin
                        m_mode = S_IDLE; e_inc = (m_first == 0); e_dec = (m_first == 1);
                    end else if (age == CW) begin
                        m_mode = S_HELD; m_th = cyc; e_inc = (m_first == 0); e_dec = (m_first == 1);
                    end
                end
                S_HELD: begin
                    if (st[0] == 1 && st[1] == 1) begin
                        m_mode = S_IDLE;
                    end
`ifdef OVEN_KEY_AUTOREPEAT_EN
                    else begin
                        age = cyc - m_th;
                        if (age >= RD && (age - RD) % RP == 0 && st[m_first] == 0) begin
                            e_inc = (m_first == 0); e_dec = (m_first == 1);
                        end
                    end
`endif
                end
                S_CHORD: begin
                    if (st[0] == 1 && st[1] == 1) m_mode = S_IDLE;
                end
                default: m_mode = S_IDLE;
            endcase
        end
        e_busy = (m_mode != S_IDLE);
    endtask

    task automatic tick();
        logic [6:0] got, exp;
        model_edge();
        @(posedge clk);
        #1;
        got = {inc_pulse, dec_pulse, confirm_pulse, keys_busy, step_idx};
        exp = {e_inc, e_dec, e_conf, e_busy, e_step};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL cycle%0d observed %b expected %b (inc dec conf busy step)", cyc, got, exp);
        end
        obs_inc  += int'(inc_pulse);
        obs_dec  += int'(dec_pulse);
        obs_conf += int'(confirm_pulse);
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_inc = obs_inc; b_dec = obs_dec; b_conf = obs_conf;
    endtask

    task automatic chk_counts(input string tag, input int n_inc, input int n_dec, input int n_conf);
        chk({tag, "_inc"}, obs_inc - b_inc, n_inc);
        chk({tag, "_dec"}, obs_dec - b_dec, n_dec);
        chk({tag, "_conf"}, obs_conf - b_conf, n_conf);
    endtask

    initial begin
        int r0, r1;
        model_reset();
        repeat (3) tick();
        chk("reset_busy", int'(keys_busy), 0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (4) tick();

        // Clean key0 tap
        mark();
        key0 = 1'b0; repeat (10) tick();
        key0 = 1'b1; repeat (30) tick();
        chk_counts("tap0", 1, 0, 0);

        // key1 joins key0 five cycles later: chord
        mark();
        key0 = 1'b0; repeat (5) tick();
        key1 = 1'b0; repeat (12) tick();
        chk("chord_busy_held", int'(keys_busy), 1);
        key0 = 1'b1; key1 = 1'b1; repeat (10) tick();
        chk("chord_busy_released", int'(keys_busy), 0);
        chk_counts("chord", 0, 0, 1);

        // Bouncy key1 never settles
        mark();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) key1 = ~key1;
            tick();
        end
        key1 = 1'b1; repeat (8) tick();
        chk_counts("glitch", 0, 0, 0);

        // Long key1 hold reaches HELD; a key0 press meanwhile is ignored
        mark();
        for (int i = 0; i < HOLD + 15; i++) begin
            key1 = (i < HOLD) ? 1'b0 : 1'b1;
            key0 = (i >= 24 && i < 30) ? 1'b0 : 1'b1;
            tick();
        end
        chk_counts("held", 0, HELD_DECS, 0);
        chk("held_busy_after", int'(keys_busy), 0);

        // Step switch decode
        sw = 6'b000100; repeat (3) tick();
        chk("step_000100", int'(step_idx), 3);
        sw = 6'b000110; repeat (3) tick();
        chk("step_000110", int'(step_idx), 0);
        sw = 6'b100001; repeat (3) tick();
        chk("step_100001", int'(step_idx), 0);
        sw = 6'b010000; repeat (3) tick();
        chk("step_010000", int'(step_idx), 5);
        sw = 6'b000001; repeat (3) tick();
        chk("step_000001", int'(step_idx), 1);

        // Asynchronous reset while key0 sits in ONE
        key0 = 1'b0; repeat (7) tick();
        chk("one_busy", int'(keys_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", int'({inc_pulse, dec_pulse, confirm_pulse, keys_busy, step_idx}), 0);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        mark();
        repeat (12) tick();
        chk_counts("post_rst_held", 0, 0, 0);
        key0 = 1'b1; repeat (12) tick();
        mark();
        key0 = 1'b0; repeat (10) tick();
        key0 = 1'b1; repeat (15) tick();
        chk_counts("post_rst_repress", 1, 0, 0);

        // Power enable low suppresses strobes; raising it over a held key does nothing
        mark();
        en = 1'b0;
        key0 = 1'b0; repeat (10) tick();
        key0 = 1'b1; repeat (15) tick();
        chk_counts("en_low_tap", 0, 0, 0);
        key0 = 1'b0; repeat (10) tick();
        en = 1'b1; repeat (30) tick();
        chk("en_rise_busy", int'(keys_busy), 0);
        key0 = 1'b1; repeat (10) tick();
        chk_counts("en_rise_held", 0, 0, 0);
        mark();
        key0 = 1'b0; repeat (10) tick();
        key0 = 1'b1; repeat (15) tick();
        chk_counts("en_fresh_tap", 1, 0, 0);

        // Randomized key activity, enable drops and switch changes
        r0 = 10; r1 = 25;
        for (int i = 0; i < 1200; i++) begin
            r0--; r1--;
            if (r0 == 0) begin key0 = ~key0; r0 = int'($urandom_range(1, 30)); end
            if (r1 == 0) begin key1 = ~key1; r1 = int'($urandom_range(1, 40)); end
            if ($urandom_range(0, 199) == 0) en = ~en;
            if (i % 17 == 0)
                sw = ($urandom_range(0, 1) == 1) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
            tick();
        end
        en = 1'b1; key0 = 1'b1; key1 = 1'b1;
        repeat (20) tick();
        chk("final_busy", int'(keys_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
